buzzer_seq: RTL and testbench

Parametrised note sequencer for the piezo buzzer output. It accepts notes into a small FIFO over a valid/ready handshake. Each note is a half-period and a duration. It plays the notes back-to-back as a square wave on `buzzer`, with rest, mute and flush support. It succeeds the fixed-tone buzzer controller and sits between the CPU/register block and the buzzer pin.

---
 rtl/buzzer_pkg.sv | 23 ++
 rtl/buzzer_note_fifo.sv | 57 +++++
 rtl/buzzer_seq.sv | 184 ++++++++++++++++++
 tb/tb_buzzer_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared encodings and defaults for the buzzer note sequencer.
// The GAP state is only reachable when BUZZER_SEQ_GAP_EN is defined.
package buzzer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_PLAY = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  localparam int unsigned DEF_TICK_DIV  = 100000;
  localparam int unsigned DEF_GAP_TICKS = 2;
  localparam int unsigned DEF_DIV_W     = 16;
  localparam int unsigned DEF_DUR_W     = 16;

  // FIFO entry layout at the default widths: half-period above duration.
  typedef struct packed {
    logic [DEF_DIV_W-1:0] half;
    logic [DEF_DUR_W-1:0] dur;
  } note_t;

endpackage

// File: rtl/buzzer_note_fifo.sv
// Synchronous note FIFO with occupancy; no write-through, flush empties it on the next edge.
// DEPTH must be a power of two so the pointers wrap naturally.
module buzzer_note_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/buzzer_seq.sv
// Note sequencer: plays queued {half-period, duration} notes as a square wave on buzzer.
// Define BUZZER_SEQ_GAP_EN to insert GAP_TICKS of silence after every played note.
module buzzer_seq
  import buzzer_pkg::*;
#(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned DUR_W     = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   note_valid,
  output logic                   note_ready,
  input  logic [DIV_W-1:0]       note_half,
  input  logic [DUR_W-1:0]       note_dur,
  input  logic                   mute,
  input  logic                   flush,
  output logic                   buzzer,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           r_state, w_state_d;
  logic [DIV_W-1:0] r_cur_half, w_cur_half_d;
  logic [DUR_W-1:0] r_dur_rem, w_dur_rem_d;
  logic [DIV_W-1:0] r_tone_cnt, w_tone_cnt_d;
  logic [PRE_W-1:0] r_pre, w_pre_d;
  logic             r_tone, w_tone_d;
  logic             r_buzzer, w_buzzer_d;

  logic [DIV_W+DUR_W-1:0] w_head;
  logic [DIV_W-1:0]       w_head_half;
  logic [DUR_W-1:0]       w_head_dur;
  logic                   w_full, w_empty, w_push, w_pop;
  logic                   w_tick, w_tone_wrap;
  state_t                 w_after_note;

`ifdef BUZZER_SEQ_GAP_EN
  localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
  logic [GAP_W-1:0] r_gap_rem, w_gap_rem_d;
`else
  logic w_unused_gap;
  assign w_unused_gap = (GAP_TICKS != 0);
`endif

  assign note_ready  = !w_full && !flush;
  assign w_push      = note_valid && note_ready;
  assign w_pop       = (r_state == ST_LOAD);
  assign w_head_half = w_head[DIV_W+DUR_W-1:DUR_W];
  assign w_head_dur  = w_head[DUR_W-1:0];
  assign busy        = (r_state != ST_IDLE);
  assign buzzer      = r_buzzer;

  buzzer_note_fifo #(
    .WIDTH (DIV_W + DUR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_flush (flush),
    .i_push  (w_push),
    .i_wdata ({note_half, note_dur}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign w_tick       = (r_pre == PRE_LAST);
  assign w_tone_wrap  = (r_cur_half != '0) && (r_tone_cnt == r_cur_half - DIV_W'(1));
  assign w_after_note = w_empty ? ST_IDLE : ST_LOAD;

  always_comb begin
    w_state_d    = r_state;
    w_cur_half_d = r_cur_half;
    w_dur_rem_d  = r_dur_rem;
    w_tone_cnt_d = r_tone_cnt;
    w_pre_d      = r_pre;
    w_tone_d     = r_tone;
`ifdef BUZZER_SEQ_GAP_EN
    w_gap_rem_d  = r_gap_rem;
`endif
    case (r_state)
      ST_IDLE: begin
        w_tone_d = 1'b0;
        if (!w_empty) w_state_d = ST_LOAD;
      end
      ST_LOAD: begin
        w_cur_half_d = w_head_half;
        w_dur_rem_d  = w_head_dur;
        w_tone_cnt_d = '0;
        w_pre_d      = '0;
        w_tone_d     = (w_head_half != '0);
        if (w_head_dur == '0) begin
          // Skipped note: chain straight into the next one if anything remains.
          w_tone_d  = 1'b0;
          w_state_d = ((level > LVL_W'(1)) || w_push) ? ST_LOAD : ST_IDLE;
        end else begin
          w_state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (w_tone_wrap) begin
          w_tone_cnt_d = '0;
          w_tone_d     = !r_tone;
        end else if (r_cur_half != '0) begin
          w_tone_cnt_d = r_tone_cnt + DIV_W'(1);
        end
        if (w_tick) begin
          w_pre_d     = '0;
          w_dur_rem_d = r_dur_rem - DUR_W'(1);
          if (r_dur_rem == DUR_W'(1)) begin
            w_tone_d = 1'b0;
`ifdef BUZZER_SEQ_GAP_EN
            w_gap_rem_d = GAP_W'(GAP_TICKS);
            w_state_d   = (GAP_TICKS == 0) ? w_after_note : ST_GAP;
`else
            w_state_d = w_after_note;
`endif
          end
        end else begin
          w_pre_d = r_pre + PRE_W'(1);
        end
      end
`ifdef BUZZER_SEQ_GAP_EN
      ST_GAP: begin
        w_tone_d = 1'b0;
        if (w_tick) begin
          w_pre_d     = '0;
          w_gap_rem_d = r_gap_rem - GAP_W'(1);
          if (r_gap_rem == GAP_W'(1)) w_state_d = w_after_note;
        end else begin
          w_pre_d = r_pre + PRE_W'(1);
        end
      end
`endif
      default: begin
        w_tone_d  = 1'b0;
        w_state_d = ST_IDLE;
      end
    endcase
    if (flush) begin
      w_state_d = ST_IDLE;
      w_tone_d  = 1'b0;
    end
  end

  // The tone phase keeps running under mute; only the pin is masked.
  assign w_buzzer_d = (w_state_d == ST_PLAY) && w_tone_d && !mute;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state    <= ST_IDLE;
      r_cur_half <= '0;
      r_dur_rem  <= '0;
      r_tone_cnt <= '0;
      r_pre      <= '0;
      r_tone     <= 1'b0;
      r_buzzer   <= 1'b0;
`ifdef BUZZER_SEQ_GAP_EN
      r_gap_rem  <= '0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_cur_half <= w_cur_half_d;
      r_dur_rem  <= w_dur_rem_d;
      r_tone_cnt <= w_tone_cnt_d;
      r_pre      <= w_pre_d;
      r_tone     <= w_tone_d;
      r_buzzer   <= w_buzzer_d;
`ifdef BUZZER_SEQ_GAP_EN
      r_gap_rem  <= w_gap_rem_d;
`endif
    end
  end

endmodule

// File: tb/tb_buzzer_seq.sv
// Self-checking bench for buzzer_seq: per-cycle expected {buzzer, busy} trace in a queue,
// plus a handshake vector table and hand-written flush / reset sequences.
module tb_buzzer_seq;

  localparam int TICK  = 10;
  localparam int DEPTH = 4;
`ifdef BUZZER_SEQ_GAP_EN
  localparam int GAP_CYC = 2 * TICK;
`else
  localparam int GAP_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        note_valid = 1'b0;
  logic        note_ready;
  logic [15:0] note_half = '0;
  logic [15:0] note_dur = '0;
  logic        mute = 1'b0;
  logic        flush = 1'b0;
  logic        buzzer;
  logic        busy;
  logic [2:0]  level;

  always #5 clk = ~clk;

  buzzer_seq #(
    .DIV_W     (16),
    .DUR_W     (16),
    .DEPTH     (DEPTH),
    .TICK_DIV  (TICK),
    .GAP_TICKS (2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_half  (note_half),
    .note_dur   (note_dur),
    .mute       (mute),
    .flush      (flush),
    .buzzer     (buzzer),
    .busy       (busy),
    .level      (level)
  );

  typedef struct {
    logic buz;
    logic bsy;
  } exp_t;

  typedef struct {
    logic valid;
    int   half;
    int   dur;
    logic ready;
    int   lvl;
  } vec_t;

  exp_t exp_q[$];
  vec_t fill_tab[5];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // One clock: sample 1 time unit after the edge and compare the next scoreboard entry.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("trace buzzer", {31'd0, buzzer}, {31'd0, e.buz});
      chk("trace busy", {31'd0, busy}, {31'd0, e.bsy});
    end
  endtask

  task automatic add_note(input int half, input int dur, input bit muted);
    exp_t e;
    e.buz = 1'b0;
    e.bsy = 1'b1;
    exp_q.push_back(e);                       // LOAD cycle
    for (int c = 0; c < dur * TICK; c++) begin
      e.buz = 1'b0;
      if (half != 0) e.buz = (((c / half) % 2) == 0) && !muted;
      exp_q.push_back(e);
    end
    if (dur > 0) begin
      e.buz = 1'b0;
      for (int g = 0; g < GAP_CYC; g++) exp_q.push_back(e);
    end
  endtask

  task automatic add_idle(input int n);
    exp_t e;
    e.buz = 1'b0;
    e.bsy = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic offer(input int half, input int dur, input bit muted, output bit acc);
    note_valid = 1'b1;
    note_half  = 16'(half);
    note_dur   = 16'(dur);
    acc        = note_ready;
    tick();
    note_valid = 1'b0;
    if (acc) add_note(half, dur, muted);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 600) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL %s drain timeout: %0d entries left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int w;

    fill_tab[0] = '{1'b1, 1, 1, 1'b1, 0};
    fill_tab[1] = '{1'b1, 2, 1, 1'b1, 1};
    fill_tab[2] = '{1'b1, 3, 1, 1'b1, 2};
    fill_tab[3] = '{1'b1, 4, 1, 1'b1, 3};
    fill_tab[4] = '{1'b1, 5, 1, 1'b0, 4};

    // Reset held for 4 edges
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("reset buzzer", {31'd0, buzzer}, 0);
      chk("reset busy", {31'd0, busy}, 0);
      chk("reset level", {29'd0, level}, 0);
      chk("reset ready", {31'd0, note_ready}, 1);
    end
    resetn = 1'b0;
    tick();
    chk("post-reset busy", {31'd0, busy}, 0);
    chk("post-reset ready", {31'd0, note_ready}, 1);

    // Single note {3,2}: rises two edges after accept, 20 PLAY cycles
    offer(3, 2, 1'b0, acc);
    chk("single accepted", {31'd0, acc}, 1);
    add_idle(3);
    drain("single");

    // Fill while a note plays
    offer(3, 2, 1'b0, acc);
    chk("fill A accepted", {31'd0, acc}, 1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      note_valid = fill_tab[i].valid;
      note_half  = 16'(fill_tab[i].half);
      note_dur   = 16'(fill_tab[i].dur);
      chk("fill ready", {31'd0, note_ready}, {31'd0, fill_tab[i].ready});
      chk("fill level", {29'd0, level}, 32'(fill_tab[i].lvl));
      acc = note_ready && fill_tab[i].valid;
      tick();
      if (acc) add_note(fill_tab[i].half, fill_tab[i].dur, 1'b0);
    end
    w = 0;
    while (!note_ready && w < 100) begin
      tick();
      w++;
    end
    chk("fill wait for pop", 32'(w), 32'(16 + GAP_CYC));
    chk("fill level after pop", {29'd0, level}, 3);
    acc = note_ready;
    tick();
    note_valid = 1'b0;
    chk("fill 5th accepted", {31'd0, acc}, 1);
    if (acc) add_note(5, 1, 1'b0);
    add_idle(3);
    drain("fill");

    // Rest, skip, tone
    offer(0, 3, 1'b0, acc);
    chk("rest accepted", {31'd0, acc}, 1);
    offer(5, 0, 1'b0, acc);
    chk("skip accepted", {31'd0, acc}, 1);
    offer(2, 1, 1'b0, acc);
    chk("tone accepted", {31'd0, acc}, 1);
    add_idle(3);
    drain("rest-skip");

    // Muted note keeps its duration
    mute = 1'b1;
    offer(4, 5, 1'b1, acc);
    chk("mute accepted", {31'd0, acc}, 1);
    add_idle(3);
    drain("mute");
    mute = 1'b0;

    // Flush mid-note with two queued notes and a push offered
    offer(3, 5, 1'b0, acc);
    offer(2, 5, 1'b0, acc);
    offer(4, 5, 1'b0, acc);
    repeat (13) tick();
    exp_q.delete();
    chk("flush pre level", {29'd0, level}, 2);
    chk("flush pre buzzer", {31'd0, buzzer}, 1);
    flush      = 1'b1;
    note_valid = 1'b1;
    note_half  = 16'd1;
    note_dur   = 16'd1;
    #1;
    chk("flush ready", {31'd0, note_ready}, 0);
    tick();
    flush      = 1'b0;
    note_valid = 1'b0;
    chk("flush busy", {31'd0, busy}, 0);
    chk("flush level", {29'd0, level}, 0);
    chk("flush buzzer", {31'd0, buzzer}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("after flush busy", {31'd0, busy}, 0);
      chk("after flush level", {29'd0, level}, 0);
    end

    // Asynchronous reset mid-PLAY
    offer(2, 5, 1'b0, acc);
    repeat (6) tick();
    exp_q.delete();
    chk("pre-reset buzzer", {31'd0, buzzer}, 1);
    #2;
    resetn = 1'b1;
    #1;
    chk("async reset buzzer", {31'd0, buzzer}, 0);
    chk("async reset busy", {31'd0, busy}, 0);
    chk("async reset level", {29'd0, level}, 0);
    tick();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("after reset busy", {31'd0, busy}, 0);
      chk("after reset level", {29'd0, level}, 0);
      chk("after reset ready", {31'd0, note_ready}, 1);
    end

    // clk/2 tone after recovering from reset
    offer(1, 1, 1'b0, acc);
    chk("half1 accepted", {31'd0, acc}, 1);
    add_idle(2);
    drain("half1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
